quad_gen_mmio: RTL

- MMIO-mapped quadrature signal generator: drives enc_a/enc_b as a two-phase Gray sequence.
- Run length, direction and edge rate are set by software.
- Transmit-side counterpart to the quadrature decoder peripheral. Used for loopback, motor emulation and bring-up.
- Sits on the same 32-bit MMIO bus as the decoder peripheral. Register map and read timing are compatible with it.

---
 rtl/quad_gen_mmio_if.sv | 22 ++
 rtl/quad_gen_mmio.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/quad_gen_mmio_if.sv
// MMIO bus bundle for the quadrature generator: byte address, write/read strobes, data.
// Latency: bus_rdata is valid one clock after the cycle that carries bus_re.
// Backpressure: none; every access completes in a single cycle.
//
// Ports (master view): bus_addr[31:0], bus_we, bus_re, bus_wdata[31:0] out; bus_rdata[31:0] in.
interface quad_gen_mmio_if;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr, bus_we, bus_re, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_we, bus_re, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/quad_gen_mmio.sv
// MMIO quadrature generator: walks enc_a/enc_b through the Gray sequence, N edges or forever.
// Latency: reads return 1 clock after bus_re; the first edge lands PERIOD clocks after START.
// Backpressure: none; bus accepts every cycle, START while busy is dropped.
//
// Ports: clk, reset (sync, active-high), bus (slave modport of quad_gen_mmio_if),
//        enc_a / enc_b registered quadrature outputs.
module quad_gen_mmio #(
  parameter int PERIOD_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  quad_gen_mmio_if.slave  bus,
  output logic            enc_a,
  output logic            enc_b
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_STEPS  = 8'h08;
  localparam logic [7:0] A_PERIOD = 8'h0C;
  localparam logic [7:0] A_REMAIN = 8'h10;
  localparam logic [7:0] A_PHASE  = 8'h14;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic                enable, cont, done, dir, run_cont;
  logic [31:0]         steps, remain;
  logic [PERIOD_W-1:0] period, run_period, timer;

  logic [7:0]          addr;
  logic                ctrl_wr;
  logic                start_go, abort_go, edge_go, last_edge;
  logic [PERIOD_W-1:0] period_eff;
  logic [31:0]         steps_mag;
  logic [31:0]         rd_mux;
  logic                unused_addr;

  assign addr        = bus.bus_addr[7:0];
  assign unused_addr = ^bus.bus_addr[31:8];
  assign ctrl_wr     = bus.bus_we && (addr == A_CTRL);
  assign period_eff  = (period == '0) ? PERIOD_W'(1) : period;
  // Two's-complement magnitude; 0x80000000 maps onto itself, i.e. 2^31 unsigned.
  assign steps_mag   = steps[31] ? (~steps + 32'd1) : steps;

  // Next-state and per-cycle strobes. Abort beats a coincident timer expiry.
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    abort_go  = 1'b0;
    edge_go   = 1'b0;
    last_edge = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_wr && bus.bus_wdata[1] && !bus.bus_wdata[2] && bus.bus_wdata[0] &&
            ((steps != 32'd0) || bus.bus_wdata[3])) begin
          start_go  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (ctrl_wr && (bus.bus_wdata[2] || !bus.bus_wdata[0])) begin
          abort_go  = 1'b1;
          state_nxt = IDLE;
        end else if (timer == PERIOD_W'(1)) begin
          edge_go = 1'b1;
          if (!run_cont && (remain == 32'd1)) begin
            last_edge = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      A_CTRL:   rd_mux = {28'd0, cont, 2'b00, enable};
      A_STATUS: rd_mux = {29'd0, dir, done, (state == RUN)};
      A_STEPS:  rd_mux = steps;
      A_PERIOD: rd_mux = {{(32-PERIOD_W){1'b0}}, period};
      A_REMAIN: rd_mux = remain;
      A_PHASE:  rd_mux = {30'd0, enc_a, enc_b};
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.bus_rdata <= 32'd0;
      enc_a         <= 1'b0;
      enc_b         <= 1'b0;
      enable        <= 1'b0;
      cont          <= 1'b0;
      steps         <= 32'd0;
      period        <= PERIOD_W'(1);
      done          <= 1'b0;
      dir           <= 1'b0;
      remain        <= 32'd0;
      run_cont      <= 1'b0;
      run_period    <= PERIOD_W'(1);
      timer         <= PERIOD_W'(1);
    end else begin
      state <= state_nxt;
      if (bus.bus_re) bus.bus_rdata <= rd_mux;

      // Register writes land regardless of run state; STEPS/PERIOD only matter at START.
      if (ctrl_wr) begin
        enable <= bus.bus_wdata[0];
        cont   <= bus.bus_wdata[3];
      end
      if (bus.bus_we && (addr == A_STEPS))  steps  <= bus.bus_wdata;
      if (bus.bus_we && (addr == A_PERIOD)) period <= bus.bus_wdata[PERIOD_W-1:0];

      if (start_go) begin
        dir        <= steps[31];
        remain     <= steps_mag;
        run_cont   <= bus.bus_wdata[3];
        run_period <= period_eff;
        timer      <= period_eff;
        done       <= 1'b0;
      end else if ((state == RUN) && !abort_go) begin
        if (edge_go) begin
          timer <= run_period;
          // Forward 00->10->11->01: A takes ~B, B takes A. Reverse is the inverse step.
          if (dir) begin
            enc_a <= enc_b;
            enc_b <= ~enc_a;
          end else begin
            enc_a <= ~enc_b;
            enc_b <= enc_a;
          end
          if (!run_cont) remain <= remain - 32'd1;
          if (last_edge) done <= 1'b1;
        end else begin
          timer <= timer - PERIOD_W'(1);
        end
      end
    end
  end

endmodule
